// File: rtl/w0rm_core_pkg.sv
// Shared helpers for the W0RM core: address-width derivation, output-stage
// state encodings and index helpers for flattened multi-port buses.
package w0rm_core_pkg;

    localparam logic [0:0] STAGE_EMPTY = 1'b0;
    localparam logic [0:0] STAGE_FULL  = 1'b1;

    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A single-register file still needs a one-bit address bus.
    function automatic int addr_width_for(input int num_registers);
        int width;
        width = log2_ceil(num_registers);
        return (width < 1) ? 1 : width;
    endfunction

    function automatic int field_lsb(input int index, input int field_width);
        return index * field_width;
    endfunction

endpackage

// File: rtl/w0rm_core_regfile_bypass.sv
// Combinational write-before-read resolver: one read address against all
// write ports, the highest-index enabled port supplying the data on a hit.
module w0rm_core_regfile_bypass
    import w0rm_core_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 4,
    parameter int NUM_WRITE_PORTS = 2,
    parameter bit REG0_ZERO       = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0]                 read_addr,
    input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] write_addr,
    input  logic [NUM_WRITE_PORTS-1:0]            write_enable,
    input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data,
    output logic                                  hit,
    output logic [DATA_WIDTH-1:0]                 data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            if (write_enable[w] &&
                write_addr[field_lsb(w, ADDR_WIDTH) +: ADDR_WIDTH] == read_addr) begin
                hit  = 1'b1;
                data = write_data[field_lsb(w, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
        // The hard-wired zero register never forwards write data.
        if (REG0_ZERO && read_addr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
    end

endmodule

// File: rtl/w0rm_core_regfile_multiport.sv
// Multi-port register file for the W0RM register-fetch stage: M write ports,
// N bypassed read ports and a registered valid/ready operand stage.
module w0rm_core_regfile_multiport
    import w0rm_core_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGISTERS   = 16,
    parameter int NUM_READ_PORTS  = 3,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int USER_WIDTH      = 1,
    parameter bit REG0_ZERO       = 1'b0,
    localparam int ADDR_WIDTH     = addr_width_for(NUM_REGISTERS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic                                  decode_valid,
    output logic                                  reg_file_ready,
    output logic                                  rfetch_valid,
    input  logic                                  alu_ready,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  port_read_addr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  port_read_data,
    input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] port_write_addr,
    input  logic [NUM_WRITE_PORTS-1:0]            port_write_enable,
    input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] port_write_data,
    input  logic [USER_WIDTH-1:0]                 user_data_in,
    output logic [USER_WIDTH-1:0]                 user_data_out
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGISTERS];

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] read_data_q [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0] read_data_d [NUM_READ_PORTS];
    logic [ADDR_WIDTH-1:0] read_addr_q [NUM_READ_PORTS];
    logic [ADDR_WIDTH-1:0] read_addr_d [NUM_READ_PORTS];
    logic [USER_WIDTH-1:0] user_q, user_d;

    logic [NUM_READ_PORTS-1:0] capture_hit;
    logic [NUM_READ_PORTS-1:0] refresh_hit;
    logic [DATA_WIDTH-1:0]     capture_data [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0]     refresh_data [NUM_READ_PORTS];

    logic accept;
    logic stalled;

    assign rfetch_valid   = (state_q == STAGE_FULL);
    assign reg_file_ready = reset || !rfetch_valid || alu_ready;
    assign accept         = decode_valid && reg_file_ready;
    assign stalled        = rfetch_valid && !alu_ready;
    assign user_data_out  = user_q;

    // Capture resolvers look at the incoming addresses; refresh resolvers
    // look at the addresses of the bundle already held in the stage.
    for (genvar r = 0; r < NUM_READ_PORTS; r++) begin : g_read_port
        w0rm_core_regfile_bypass #(
            .DATA_WIDTH      (DATA_WIDTH),
            .ADDR_WIDTH      (ADDR_WIDTH),
            .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
            .REG0_ZERO       (REG0_ZERO)
        ) u_capture (
            .read_addr    (port_read_addr[field_lsb(r, ADDR_WIDTH) +: ADDR_WIDTH]),
            .write_addr   (port_write_addr),
            .write_enable (port_write_enable),
            .write_data   (port_write_data),
            .hit          (capture_hit[r]),
            .data         (capture_data[r])
        );

        w0rm_core_regfile_bypass #(
            .DATA_WIDTH      (DATA_WIDTH),
            .ADDR_WIDTH      (ADDR_WIDTH),
            .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
            .REG0_ZERO       (REG0_ZERO)
        ) u_refresh (
            .read_addr    (read_addr_q[r]),
            .write_addr   (port_write_addr),
            .write_enable (port_write_enable),
            .write_data   (port_write_data),
            .hit          (refresh_hit[r]),
            .data         (refresh_data[r])
        );

        assign port_read_data[field_lsb(r, DATA_WIDTH) +: DATA_WIDTH] = read_data_q[r];
    end

    // Ascending port order lets the highest-index write win a collision.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            if (port_write_enable[w] &&
                !(REG0_ZERO && port_write_addr[field_lsb(w, ADDR_WIDTH) +: ADDR_WIDTH] == '0) &&
                int'(port_write_addr[field_lsb(w, ADDR_WIDTH) +: ADDR_WIDTH]) < NUM_REGISTERS) begin
                regs_d[port_write_addr[field_lsb(w, ADDR_WIDTH) +: ADDR_WIDTH]] =
                    port_write_data[field_lsb(w, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            read_data_d[p] = read_data_q[p];
            read_addr_d[p] = read_addr_q[p];
            if (accept) begin
                read_addr_d[p] = port_read_addr[field_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH];
                if (capture_hit[p]) begin
                    read_data_d[p] = capture_data[p];
                end else if (REG0_ZERO && read_addr_d[p] == '0) begin
                    read_data_d[p] = '0;
                end else if (int'(read_addr_d[p]) < NUM_REGISTERS) begin
                    read_data_d[p] = regs_q[read_addr_d[p]];
                end else begin
                    read_data_d[p] = '0;
                end
            end else if (stalled && refresh_hit[p]) begin
                read_data_d[p] = refresh_data[p];
            end
        end
        user_d = accept ? user_data_in : user_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STAGE_EMPTY: if (accept) state_d = STAGE_FULL;
            default:     if (alu_ready && !accept) state_d = STAGE_EMPTY;
        endcase
        if (flush) begin
            state_d = STAGE_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STAGE_EMPTY;
            user_q  <= '0;
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs_q[i] <= '0;
            end
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                read_data_q[p] <= '0;
                read_addr_q[p] <= '0;
            end
        end else begin
            state_q     <= state_d;
            user_q      <= user_d;
            regs_q      <= regs_d;
            read_data_q <= read_data_d;
            read_addr_q <= read_addr_d;
        end
    end

endmodule
